// File: rtl/i2s_sink_if.sv
// Bundles the I2S pin trio with the valid/ready pair stream toward the capture FIFO.
interface i2s_sink_if #(
  parameter int SAMPLE_BITS = 24
);
  logic                       bck;
  logic                       lrck;
  logic                       sdata;
  logic [2*SAMPLE_BITS-1:0]   out_data;
  logic                       out_valid;
  logic                       out_ready;

  modport master (
    output bck, lrck, sdata, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  bck, lrck, sdata, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/i2s_sink.sv
// I2S slave receiver: oversamples BCK/LRCK/SDATA in the clk domain and emits {left,right} pairs.
module i2s_sink #(
  parameter int SAMPLE_BITS = 24,
  parameter int DATA_DELAY  = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         clear_status,
  output logic         overflow,
  output logic         frame_error,
  i2s_sink_if.slave    bus
);
  localparam int KW = $clog2(DATA_DELAY + SAMPLE_BITS + 1);
  localparam logic [KW-1:0] K_FIRST = KW'(DATA_DELAY);
  localparam logic [KW-1:0] K_SB    = KW'(SAMPLE_BITS);
  localparam logic [KW-1:0] K_LAST  = KW'(DATA_DELAY + SAMPLE_BITS - 1);
  localparam logic [KW-1:0] K_MAX   = KW'(DATA_DELAY + SAMPLE_BITS);

  localparam logic [1:0] S_UNSYNC = 2'd0;
  localparam logic [1:0] S_LEFT   = 2'd1;
  localparam logic [1:0] S_RIGHT  = 2'd2;

  logic [2:0]               r_bckSync;
  logic [1:0]               r_lrckSync;
  logic [1:0]               r_sdataSync;
  logic                     r_prevLrck;
  logic [KW-1:0]            r_k;
  logic [1:0]               r_state;
  logic [SAMPLE_BITS-1:0]   r_left;
  logic [SAMPLE_BITS-1:0]   r_right;
  logic [2*SAMPLE_BITS-1:0] r_outData;
  logic                     r_outValid;
  logic                     r_overflow;
  logic                     r_frameError;

  logic                     w_rise;
  logic                     w_lrck;
  logic                     w_sdata;
  logic                     w_edge;
  logic [KW-1:0]            w_k;
  logic [KW-1:0]            w_offset;
  logic                     w_capture;
  logic                     w_short;
  logic                     w_feEvent;
  logic                     w_emit;
  logic                     w_ovfEvent;
  logic [2*SAMPLE_BITS-1:0] w_pair;

  assign w_rise  = r_bckSync[1] & ~r_bckSync[2];
  assign w_lrck  = r_lrckSync[1];
  assign w_sdata = r_sdataSync[1];
  assign w_edge  = w_lrck != r_prevLrck;
  assign w_k     = w_edge ? '0 : ((r_k == K_MAX) ? r_k : r_k + 1'b1);
  // Wrapping subtract folds the lower window bound into one compare.
  assign w_offset  = w_k - K_FIRST;
  assign w_capture = w_offset < K_SB;
  assign w_short   = r_k < K_LAST;

  assign w_feEvent  = w_rise && enable && w_edge && w_short && (r_state != S_UNSYNC);
  assign w_emit     = w_rise && enable && !w_edge && (r_state == S_RIGHT) && (w_k == K_LAST);
  assign w_ovfEvent = w_emit && r_outValid && !bus.out_ready;
  assign w_pair     = {r_left, r_right[SAMPLE_BITS-2:0], w_sdata};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bckSync   <= '0;
      r_lrckSync  <= '0;
      r_sdataSync <= '0;
    end else begin
      r_bckSync   <= {r_bckSync[1:0], bus.bck};
      r_lrckSync  <= {r_lrckSync[0], bus.lrck};
      r_sdataSync <= {r_sdataSync[0], bus.sdata};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prevLrck <= 1'b0;
      r_k        <= '0;
      r_left     <= '0;
      r_right    <= '0;
    end else if (w_rise) begin
      r_prevLrck <= w_lrck;
      r_k        <= w_k;
      if (w_capture) begin
        if (w_lrck) r_right <= {r_right[SAMPLE_BITS-2:0], w_sdata};
        else        r_left  <= {r_left[SAMPLE_BITS-2:0], w_sdata};
      end
    end
  end

  // A short left half drops back to UNSYNC so the following right half emits nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_UNSYNC;
    end else if (!enable) begin
      r_state <= S_UNSYNC;
    end else if (w_rise && w_edge) begin
      case (r_state)
        S_UNSYNC: if (!w_lrck) r_state <= S_LEFT;
        S_LEFT:   r_state <= w_short ? S_UNSYNC : S_RIGHT;
        S_RIGHT:  r_state <= S_LEFT;
        default:  r_state <= S_UNSYNC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outData  <= '0;
      r_outValid <= 1'b0;
    end else if (w_emit && (!r_outValid || bus.out_ready)) begin
      r_outData  <= w_pair;
      r_outValid <= 1'b1;
    end else if (r_outValid && bus.out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  // New events take priority over a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow   <= 1'b0;
      r_frameError <= 1'b0;
    end else begin
      if (w_ovfEvent)        r_overflow <= 1'b1;
      else if (clear_status) r_overflow <= 1'b0;
      if (w_feEvent)         r_frameError <= 1'b1;
      else if (clear_status) r_frameError <= 1'b0;
    end
  end

  assign bus.out_data  = r_outData;
  assign bus.out_valid = r_outValid;
  assign overflow      = r_overflow;
  assign frame_error   = r_frameError;
endmodule
